// File: rtl/mailbox_ctrl_if.sv
// Mailbox controller bus: requester handshakes, store write port and
// consumer notification, bundled so the controller has a single bus port.
interface mailbox_ctrl_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_last;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_last;
  logic        req1_ready;
  logic        mem_wr;
  logic [1:0]  mem_wr_sel;
  logic [31:0] mem_wdata;
  logic        mem_wr_ready;
  logic        doorbell;
  logic        msg_src;
  logic [2:0]  msg_len;
  logic        msg_trunc;
  logic        cons_ack;
  logic        busy;

  // Controller side
  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  mem_wr_ready, cons_ack,
    output req0_ready, req1_ready,
    output mem_wr, mem_wr_sel, mem_wdata,
    output doorbell, msg_src, msg_len, msg_trunc, busy
  );

  // Requesters, store and consumer side
  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output mem_wr_ready, cons_ack,
    input  req0_ready, req1_ready,
    input  mem_wr, mem_wr_sel, mem_wdata,
    input  doorbell, msg_src, msg_len, msg_trunc, busy
  );
endinterface

// File: rtl/mailbox_ctrl.sv
// Write-side mailbox controller: round-robin between two requesters, writes
// the granted message into the store, then rings a doorbell and stays locked
// until the consumer acknowledges.
//
// state  | meaning
// IDLE   | waiting for any requester valid; arbitration happens here
// WRITE  | streaming granted requester's words into the store
// NOTIFY | doorbell up, mailbox locked until cons_ack
module mailbox_ctrl #(
  parameter int MESSAGE_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  mailbox_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, NOTIFY} state_t;

  localparam logic [2:0] WCNT_MAX = 3'(MESSAGE_DEPTH - 1);

  state_t      state, state_nxt;
  logic        grant, grant_nxt;
  logic        last_grant;
  logic [2:0]  wcnt;
  logic        doorbell_q, src_q, trunc_q;
  logic [2:0]  len_q;

  logic        g_valid, g_last;
  logic [31:0] g_data;
  logic        xfer, msg_end;
  logic        any_valid;

  logic        ready0, ready1, wr;
  logic [1:0]  wr_sel;
  logic [31:0] wdata;

  // Mux the granted requester onto a common view
  always_comb begin
    g_valid   = grant ? bus.req1_valid : bus.req0_valid;
    g_data    = grant ? bus.req1_data  : bus.req0_data;
    g_last    = grant ? bus.req1_last  : bus.req0_last;
    any_valid = bus.req0_valid | bus.req1_valid;
    xfer      = (state == WRITE) & g_valid & bus.mem_wr_ready;
    // A full slot ends the message even without last; the rest is re-sent later
    msg_end   = xfer & (g_last | (wcnt == WCNT_MAX));
  end

  // Next-state, arbitration and store-port outputs
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ready0    = 1'b0;
    ready1    = 1'b0;
    wr        = 1'b0;
    wr_sel    = 2'd0;
    wdata     = 32'd0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = WRITE;
          if (bus.req0_valid & bus.req1_valid) grant_nxt = ~last_grant;
          else                                 grant_nxt = bus.req1_valid;
        end
      end
      WRITE: begin
        ready0 = ~grant & bus.mem_wr_ready;
        ready1 =  grant & bus.mem_wr_ready;
        wr     = g_valid & bus.mem_wr_ready;
        wr_sel = wcnt[1:0];
        wdata  = g_data;
        if (msg_end) state_nxt = NOTIFY;
      end
      NOTIFY: begin
        if (bus.cons_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant, word counter and doorbell/message descriptor registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wcnt       <= 3'd0;
      doorbell_q <= 1'b0;
      src_q      <= 1'b0;
      len_q      <= 3'd0;
      trunc_q    <= 1'b0;
    end else begin
      grant <= grant_nxt;
      if ((state == IDLE) && any_valid) wcnt <= 3'd0;
      else if (xfer)                    wcnt <= wcnt + 3'd1;
      if (msg_end) begin
        len_q      <= wcnt + 3'd1;
        src_q      <= grant;
        trunc_q    <= (wcnt == WCNT_MAX) & ~g_last;
        last_grant <= grant;
        doorbell_q <= 1'b1;
      end else if ((state == NOTIFY) && bus.cons_ack) begin
        doorbell_q <= 1'b0;
        trunc_q    <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.mem_wr     = wr;
  assign bus.mem_wr_sel = wr_sel;
  assign bus.mem_wdata  = wdata;
  assign bus.doorbell   = doorbell_q;
  assign bus.msg_src    = src_q;
  assign bus.msg_len    = len_q;
  assign bus.msg_trunc  = trunc_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mailbox_ctrl.sv
// Bench for mailbox_ctrl: message-level model (chunking, round robin) feeds
// expected write and doorbell queues, checked every negedge by one monitor.
module tb_mailbox_ctrl;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  mailbox_ctrl_if bus();

  mailbox_ctrl #(.MESSAGE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0]  exp_sel[$];
  logic [31:0] exp_data[$];
  bit          exp_src[$];
  int          exp_len[$];
  bit          exp_trunc[$];
  bit          obs_src[$];
  bit          m_last = 1'b1;
  bit          auto_ack = 1'b1;
  bit          man_ack = 1'b0;
  bit          prev_db = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Message model: split into slot-sized chunks, each a run of writes and a doorbell
  function automatic void model_msg(input bit r, input int n, input logic [31:0] base);
    int off = 0;
    while (off < n) begin
      int len = (n - off > DEPTH) ? DEPTH : n - off;
      for (int j = 0; j < len; j++) begin
        exp_sel.push_back(2'(j));
        exp_data.push_back(base + 32'(off + j));
      end
      exp_src.push_back(r);
      exp_len.push_back(len);
      exp_trunc.push_back((len == DEPTH) && (off + len < n));
      m_last = r;
      off += len;
    end
  endfunction

  // Consumer: acknowledge in the first cycle the doorbell is seen
  initial begin
    bus.cons_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.cons_ack = (auto_ack & bus.doorbell) | man_ack;
    end
  end

  // Monitor: protocol rules plus the model's write and doorbell queues
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      chk("wr_is_xfer", 32'(bus.mem_wr),
          32'((bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready)));
      if (bus.doorbell) begin
        chk("notify_quiet", 32'({bus.req0_ready, bus.req1_ready, bus.mem_wr, bus.mem_wr_sel}), 32'd0);
        chk("notify_wdata", bus.mem_wdata, 32'd0);
      end
      if (bus.mem_wr) begin
        if (exp_sel.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=sel%0d/%0h required=none", bus.mem_wr_sel, bus.mem_wdata);
        end else begin
          chk("wr_sel", 32'(bus.mem_wr_sel), 32'(exp_sel.pop_front()));
          chk("wr_data", bus.mem_wdata, exp_data.pop_front());
        end
      end
      if (bus.doorbell && !prev_db) begin
        obs_src.push_back(bus.msg_src);
        if (exp_src.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_doorbell actual=src%0d required=none", bus.msg_src);
        end else begin
          chk("msg_src", 32'(bus.msg_src), 32'(exp_src.pop_front()));
          chk("msg_len", 32'(bus.msg_len), 32'(exp_len.pop_front()));
          chk("msg_trunc", 32'(bus.msg_trunc), 32'(exp_trunc.pop_front()));
        end
      end
    end
    prev_db = bus.doorbell;
  end

  task automatic set_req(input bit r, input logic v, input logic [31:0] d, input logic l);
    if (r) begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end else begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end
  endtask

  // Present one word and hold it until accepted; returns just after the transfer edge
  task automatic push_word(input bit r, input logic [31:0] d, input logic l, output bit ok);
    int cyc = 0;
    set_req(r, 1'b1, d, l);
    do begin
      @(negedge clk);
      cyc++;
    end while (!(r ? bus.req1_ready : bus.req0_ready) && cyc < 200);
    ok = r ? bus.req1_ready : bus.req0_ready;
    if (!ok) fail("word_accept");
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit r, input int n, input logic [31:0] base, input int gap_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        set_req(r, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
      end
      push_word(r, base + 32'(i), (i == n - 1), ok);
      if (!ok) break;
    end
    set_req(r, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wait_db(input string name);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.doorbell && cyc < 200);
    if (!bus.doorbell) fail(name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk({name, "_wr"}, 32'({bus.mem_wr, bus.mem_wr_sel}), 32'd0);
    chk({name, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({name, "_msg"}, 32'({bus.doorbell, bus.msg_src, bus.msg_len, bus.msg_trunc}), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    bus.mem_wr_ready = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 32'd0, 1'b0);
    #1;
    chk_all_zero("reset");
    #21;
    reset = 1'b0;

    // Single 3-word message from req0
    model_msg(1'b0, 3, 32'hA000_0000);
    fork
      send(1'b0, 3, 32'hA000_0000, -1);
      wait_db("single_db");
    join
    chk("single_len", 32'(bus.msg_len), 32'd3);
    chk("single_src", 32'(bus.msg_src), 32'd0);
    chk("single_trunc", 32'(bus.msg_trunc), 32'd0);
    @(posedge clk);
    #1;
    chk("single_db_clr", 32'(bus.doorbell), 32'd0);
    chk("single_busy", 32'(bus.busy), 32'd0);

    // Backpressure for 2 cycles and a 1-cycle bubble inside a full-slot message
    model_msg(1'b0, 4, 32'hE000_0010);
    fork
      send(1'b0, 4, 32'hE000_0010, 2);
      begin
        repeat (2) @(posedge clk);
        #1 bus.mem_wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.mem_wr_ready = 1'b1;
      end
      wait_db("bp_db");
    join
    chk("bp_len", 32'(bus.msg_len), 32'd4);
    chk("bp_trunc", 32'(bus.msg_trunc), 32'd0);
    @(posedge clk);
    #1;

    // Truncation: 6 words from req1 become 4 (truncated) + 2
    model_msg(1'b1, 6, 32'hD000_0000);
    fork
      send(1'b1, 6, 32'hD000_0000, -1);
      begin
        wait_db("trunc_db1");
        chk("trunc1_len", 32'(bus.msg_len), 32'd4);
        chk("trunc1_flag", 32'(bus.msg_trunc), 32'd1);
        @(posedge clk);
        #1;
        wait_db("trunc_db2");
        chk("trunc2_len", 32'(bus.msg_len), 32'd2);
        chk("trunc2_flag", 32'(bus.msg_trunc), 32'd0);
        chk("trunc2_src", 32'(bus.msg_src), 32'd1);
      end
    join
    @(posedge clk);
    #1;

    // Lock while notified
    auto_ack = 1'b0;
    model_msg(1'b0, 1, 32'hC000_0000);
    fork
      send(1'b0, 1, 32'hC000_0000, -1);
      wait_db("lock_db");
    join
    @(posedge clk);
    #1;
    model_msg(1'b0, 1, 32'hC000_0001);
    set_req(1'b0, 1'b1, 32'hC000_0001, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("lock_ready", 32'(bus.req0_ready), 32'd0);
      chk("lock_db_held", 32'(bus.doorbell), 32'd1);
    end
    @(posedge clk);
    #1 man_ack = 1'b1;
    @(posedge clk);
    #1 man_ack = 1'b0;
    chk("lock_db_clr", 32'(bus.doorbell), 32'd0);
    chk("lock_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("lock_idle_ready", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    chk("lock_grant_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 32'd0, 1'b0);
    auto_ack = 1'b1;
    chk("lock_db2", 32'(bus.doorbell), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Tie round robin from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    begin
      int pend[2];
      int k[2];
      pend[0] = 2; pend[1] = 2; k[0] = 0; k[1] = 0;
      repeat (4) begin
        bit pick;
        if (pend[0] > 0 && pend[1] > 0) pick = ~m_last;
        else                            pick = (pend[1] > 0);
        model_msg(pick, 1, (pick ? 32'hB100_0000 : 32'hB000_0000) + 32'(k[pick]));
        k[pick]++;
        pend[pick]--;
      end
    end
    obs_src.delete();
    fork
      begin
        send(1'b0, 1, 32'hB000_0000, -1);
        send(1'b0, 1, 32'hB000_0001, -1);
      end
      begin
        send(1'b1, 1, 32'hB100_0000, -1);
        send(1'b1, 1, 32'hB100_0001, -1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    if (obs_src.size() != 4) begin
      total++;
      bad++;
      $display("FAIL tie_count actual=%0d required=4", obs_src.size());
    end else begin
      chk("tie_order", 32'({obs_src[0], obs_src[1], obs_src[2], obs_src[3]}), 32'b0101);
    end

    // Async reset after 2 words of a 4-word message
    exp_sel.push_back(2'd0); exp_data.push_back(32'hF000_0000);
    exp_sel.push_back(2'd1); exp_data.push_back(32'hF000_0001);
    push_word(1'b0, 32'hF000_0000, 1'b0, ok);
    push_word(1'b0, 32'hF000_0001, 1'b0, ok);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    chk_all_zero("rst_mid");
    chk("rst_wr_seen", 32'(exp_sel.size()), 32'd0);
    m_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_msg(1'b0, 1, 32'hF100_0000);
    fork
      send(1'b0, 1, 32'hF100_0000, -1);
      wait_db("rst_db");
    join
    chk("rst_fresh_len", 32'(bus.msg_len), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    chk("left_writes", 32'(exp_sel.size()), 32'd0);
    chk("left_msgs", 32'(exp_src.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mailbox_ctrl.md
# mailbox_ctrl

Write-side controller for the fabric mailbox message store. Two requesters each stream a message of 1..MESSAGE_DEPTH 32-bit words, and a round-robin arbiter grants one of them at a time. The controller sequences the granted words into the mailbox store (write strobe, word select, data), then raises a registered doorbell with source ID and length. It holds the mailbox locked until the consumer acknowledges. The consumer reads the store directly; this block never drives the read side.

## Interface
- MESSAGE_DEPTH, 4, words per message slot; legal range 1..4 (word select is 2 bits)
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately
- req0_valid / req1_valid  in  1  requester N presents a word
- req0_data / req1_data  in  32  word payload
- req0_last / req1_last  in  1  final word of the message
- req0_ready / req1_ready  out  1  word accepted this cycle (valid & ready = transfer)
- mem_wr  out  1  write strobe to mailbox store
- mem_wr_sel  out  2  word index written
- mem_wdata  out  32  write data
- mem_wr_ready  in  1  store can accept the write
- doorbell  out  1  complete message available; held until consumer ack
- msg_src  out  1  requester that wrote the current message
- msg_len  out  3  word count of current message, 1..MESSAGE_DEPTH
- msg_trunc  out  1  message was truncated at MESSAGE_DEPTH without last
- cons_ack  in  1  consumer has finished reading; releases mailbox
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, NOTIFY.
- IDLE:
  - If any reqN_valid, register a grant, clear word counter `wcnt`, go to WRITE.
  - Both valid: grant the requester not granted last. `last_grant` resets to 1, so req0 wins the first tie.
  - Single valid: grant it regardless of `last_grant`.
- WRITE, granted requester g:
  - reqg_ready = mem_wr_ready.
  - mem_wr = reqg_valid & mem_wr_ready.
  - mem_wr_sel = wcnt[1:0].
  - mem_wdata = reqg_data.
  - The non-granted ready is 0.
- On each transfer, `wcnt` increments.
- End of message is a transfer with reqg_last=1, or a transfer with wcnt==MESSAGE_DEPTH-1. On end of message:
  - msg_len <= wcnt+1.
  - msg_src <= g.
  - msg_trunc <= (wcnt==MESSAGE_DEPTH-1) & ~reqg_last.
  - last_grant <= g.
  - doorbell <= 1; go to NOTIFY.
- Truncation: the requester's remaining words stay un-acked. They are presented again as a new message at the next arbitration.
- NOTIFY:
  - Both readies 0; mem_wr 0.
  - On cons_ack: doorbell <= 0, msg_trunc <= 0, go to IDLE.
  - msg_src and msg_len hold their value until the next message end.
- cons_ack outside NOTIFY is ignored.
- While not in WRITE: mem_wr_sel = 0 and mem_wdata = 0.

## Timing
- Reset values: all readies 0, mem_wr 0, mem_wr_sel 0, mem_wdata 0, doorbell 0, msg_src 0, msg_len 0, msg_trunc 0, busy 0. State IDLE, wcnt 0, last_grant 1.
- Arbitration latency: valid sampled in IDLE at edge k puts WRITE in effect from edge k; first ready can assert in cycle k+1.
- Throughput: one word per cycle when valid & mem_wr_ready are continuously high.
- An N-word message takes N WRITE cycles, plus 1 IDLE cycle, before the doorbell.
- Doorbell rises on the edge after the last transfer. Earliest ack is sampled in that same cycle; doorbell falls at the next edge.
- Earliest next grant: the cycle after return to IDLE, giving 2 dead cycles between messages.
- mem_wr_ready low stalls the write: wcnt holds and the requester must hold its data.
- reqg_valid low in WRITE is a bubble: no write, wcnt holds, no timeout.
- Reset mid-WRITE or mid-NOTIFY: the partial or unacknowledged message is abandoned and doorbell drops asynchronously. Store contents are undefined and the requester restarts its message.
- Arbitration decisions are not made in WRITE/NOTIFY. A requester that raises valid during them waits.

## Test plan
- **Single message.** req0 sends 3 words A0,A1,A2 (last on A2), mem_wr_ready=1.
  - Expect mem_wr on 3 consecutive cycles, sel 0,1,2.
  - Next edge: doorbell=1, msg_src=0, msg_len=3, msg_trunc=0.
  - cons_ack -> doorbell=0, busy=0.
- **Tie round-robin.** Both requesters valid with 1-word messages, ack immediately, 4 messages.
  - Grants in order 0,1,0,1; msg_src follows.
- **Truncation.** MESSAGE_DEPTH=4; req1 sends 6 words, last on word 6.
  - First message: msg_len=4, msg_trunc=1.
  - After ack, words 5..6 arrive as a second message: sel 0,1, msg_len=2, msg_trunc=0.
- **Backpressure and bubbles.** mem_wr_ready low for 2 cycles mid-message, plus a 1-cycle valid gap.
  - No writes during stalls; sel sequence is contiguous 0..3; data is unchanged.
- **Lock while notified.** During NOTIFY, req0 valid.
  - req0_ready stays 0 and no mem_wr until ack; grant follows the cycle after IDLE.
- **Async reset mid-WRITE.** Assert reset after 2 words.
  - All outputs 0 immediately; busy=0.
  - A fresh 1-word message after release completes with msg_len=1.
